// File: rtl/ahb_slave_mem_responder_if.sv
// AHB-Lite bus bundle between a master (or bus fabric) and the memory responder.
interface ahb_slave_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    hselx;
  logic [ADDR_WIDTH-1:0]   haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH/8-1:0] hwstrb;
  logic                    hready;
  logic                    hreadyout;
  logic                    hresp;
  logic [DATA_WIDTH-1:0]   hrdata;
  logic                    hexokay;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
    input  hreadyout, hresp, hrdata, hexokay
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
    output hreadyout, hresp, hrdata, hexokay
  );
endinterface

// File: rtl/ahb_slave_mem_responder.sv
// AHB-Lite subordinate serving a byte-addressed local memory with a fixed
// number of wait states per OKAY data phase and a two-cycle ERROR response
// for out-of-range, oversized or misaligned accesses.
module ahb_slave_mem_responder #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned           WAIT_STATES   = 0
) (
  input  logic                      hclk,
  input  logic                      hreset,
  ahb_slave_mem_responder_if.slave  bus
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(STRB_W);
  localparam int unsigned WORD_BITS = MEM_ADDR_BITS - LANE_BITS;
  localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_BITS;
  localparam logic [2:0]  MAX_SIZE  = 3'(LANE_BITS);
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_READY, S_WAIT, S_ERR1, S_ERR2} state_e;

  // Lanes touched by a transfer: 2^size lanes starting at the address lane.
  function automatic logic [STRB_W-1:0] size_mask(input logic [LANE_BITS-1:0] lane,
                                                  input logic [2:0] size);
    logic [STRB_W-1:0] m;
    m = '0;
    for (int k = 0; k < STRB_W; k++) begin
      if ((k >= int'(lane)) && (k < int'(lane) + (1 << size))) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Any of: outside the owned window, wider than the bus, or misaligned.
  function automatic logic access_error(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [2:0] size);
    logic [ADDR_WIDTH-1:0] off;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    off       = addr - BASE_ADDR;
    range_err = |(off >> MEM_ADDR_BITS);
    size_err  = (size > MAX_SIZE);
    align_err = |(addr[6:0] & ((7'd1 << size) - 7'd1));
    return range_err | size_err | align_err;
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;

  logic                   dp_valid_q;
  logic                   dp_write_q;
  logic [WORD_BITS-1:0]   dp_word_q;
  logic [STRB_W-1:0]      dp_mask_q;
  logic [DATA_WIDTH-1:0]  rd_buf_q;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [7:0]             mem [MEM_BYTES];

  logic                   hreadyout_w;
  logic                   accept;
  logic                   acc_err;
  logic [WORD_BITS-1:0]   acc_word;
  logic [STRB_W-1:0]      acc_mask;
  logic                   wr_en;
  logic                   rd_done;
  logic                   fetch;
  logic [DATA_WIDTH-1:0]  fetch_data;
  logic                   unused_bus;

  assign hreadyout_w = (state_q == S_READY) || (state_q == S_ERR2);
  assign accept      = bus.hselx & bus.hready & bus.htrans[1] & hreadyout_w;
  assign acc_err     = access_error(bus.haddr, bus.hsize);
  // BASE_ADDR is aligned to the memory size, so low address bits index the memory directly.
  assign acc_word    = bus.haddr[MEM_ADDR_BITS-1:LANE_BITS];
  assign acc_mask    = size_mask(bus.haddr[LANE_BITS-1:0], bus.hsize);
  assign wr_en       = hreadyout_w & dp_valid_q & dp_write_q;
  assign rd_done     = hreadyout_w & dp_valid_q & ~dp_write_q;
  assign fetch       = accept & ~acc_err & ~bus.hwrite;

  // Burst type and SEQ/NONSEQ distinction do not change behaviour.
  assign unused_bus  = ^{bus.hburst, bus.htrans[0]};

  assign bus.hreadyout = hreadyout_w;
  assign bus.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.hrdata    = rd_done ? rd_buf_q : hold_q;
  assign bus.hexokay   = 1'b0;

  // State register for the data-phase response FSM.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= S_READY;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: OKAY phases take WAIT_STATES+1 cycles, errors always two.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_READY, S_ERR2: begin
        state_d = S_READY;
        if (accept) begin
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_READY;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_READY;
    endcase
  end

  // Data-phase holding registers and the held read value.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_word_q  <= '0;
      dp_mask_q  <= '0;
      hold_q     <= '0;
    end else begin
      if (rd_done) hold_q <= rd_buf_q;
      if (hreadyout_w) begin
        dp_valid_q <= accept & ~acc_err;
        if (accept) begin
          dp_write_q <= bus.hwrite;
          dp_word_q  <= acc_word;
          dp_mask_q  <= acc_mask;
        end
      end
    end
  end

  // Read fetch; a write completing on the accept edge forwards its strobed bytes.
  always_comb begin
    fetch_data = '0;
    for (int k = 0; k < STRB_W; k++) begin
      if (acc_mask[k]) begin
        if (wr_en && (dp_word_q == acc_word) && dp_mask_q[k] && bus.hwstrb[k])
          fetch_data[8*k +: 8] = bus.hwdata[8*k +: 8];
        else
          fetch_data[8*k +: 8] = mem[{acc_word, LANE_BITS'(k)}];
      end
    end
  end

  // Memory byte writes on the completing edge and read capture at accept.
  always_ff @(posedge hclk) begin
    for (int k = 0; k < STRB_W; k++) begin
      if (wr_en && dp_mask_q[k] && bus.hwstrb[k])
        mem[{dp_word_q, LANE_BITS'(k)}] <= bus.hwdata[8*k +: 8];
    end
    if (fetch) rd_buf_q <= fetch_data;
  end

endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) behind one pipelined master.
module tb_ahb_slave_mem_responder;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rd;
    int          len;
  } exp_t;

  logic        hclk;
  logic        hreset;
  logic        msel;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [31:0] m_hwdata;
  logic [3:0]  m_hwstrb;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_wstrb;

  int          n_cmp;
  int          n_err;
  exp_t        q[$];
  logic [31:0] last_rd [2];
  bit          dp_act;
  int          cyc;
  logic        resp_first;

  ahb_slave_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_slave_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  ahb_slave_mem_responder #(.WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
  ahb_slave_mem_responder #(.WAIT_STATES(3)) dut3 (.hclk(hclk), .hreset(hreset), .bus(bus3));

  assign bus0.hselx  = ~msel;
  assign bus3.hselx  = msel;
  assign bus0.hready = bus0.hreadyout;
  assign bus3.hready = bus3.hreadyout;
  assign bus0.haddr  = m_haddr;   assign bus3.haddr  = m_haddr;
  assign bus0.htrans = m_htrans;  assign bus3.htrans = m_htrans;
  assign bus0.hwrite = m_hwrite;  assign bus3.hwrite = m_hwrite;
  assign bus0.hsize  = m_hsize;   assign bus3.hsize  = m_hsize;
  assign bus0.hburst = m_hburst;  assign bus3.hburst = m_hburst;
  assign bus0.hwdata = m_hwdata;  assign bus3.hwdata = m_hwdata;
  assign bus0.hwstrb = m_hwstrb;  assign bus3.hwstrb = m_hwstrb;

  wire        mon_ready = msel ? bus3.hreadyout : bus0.hreadyout;
  wire        mon_resp  = msel ? bus3.hresp     : bus0.hresp;
  wire [31:0] mon_rdata = msel ? bus3.hrdata    : bus0.hrdata;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Hold the current address phase until the selected responder is ready.
  task automatic wait_ready();
    bit r;
    int guard;
    guard = 0;
    do begin
      @(negedge hclk);
      r = mon_ready;
      @(posedge hclk);
      #1;
      guard++;
    end while (!r && guard < 40);
    if (!r) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: hreadyout stuck low at t=%0t", $time);
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input bit err, input logic [31:0] rd);
    exp_t e;
    m_htrans = trans;
    m_haddr  = addr;
    m_hwrite = wr;
    m_hsize  = size;
    m_hwdata = pend_wdata;
    m_hwstrb = pend_wstrb;
    wait_ready();
    e.wr  = wr;
    e.err = err;
    e.rd  = rd;
    e.len = err ? 2 : (msel ? 4 : 1);
    q.push_back(e);
    pend_wdata = wdata;
    pend_wstrb = wstrb;
  endtask

  task automatic idle_bus();
    m_htrans = 2'b00;
    m_hwdata = pend_wdata;
    m_hwstrb = pend_wstrb;
    wait_ready();
    pend_wdata = '0;
    pend_wstrb = '0;
  endtask

  // Monitor: pops one expectation per completed data phase.
  always @(negedge hclk) begin
    if (hreset) begin
      q.delete();
      dp_act = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      if (dp_act) begin
        cyc++;
        if (cyc == 1) resp_first = mon_resp;
        if (mon_ready) begin
          if (q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("phase_len", cyc, e.len);
            check("hresp_first", {31'd0, resp_first}, {31'd0, e.err});
            check("hresp_last", {31'd0, mon_resp}, {31'd0, e.err});
            if (!e.wr && !e.err) begin
              check("hrdata", mon_rdata, e.rd);
              last_rd[msel] = e.rd;
            end else begin
              check("hrdata_hold", mon_rdata, last_rd[msel]);
            end
          end
          dp_act = 1'b0;
        end
      end
      if (mon_ready && m_htrans[1]) begin
        dp_act = 1'b1;
        cyc    = 0;
      end
    end
  end

  localparam logic [2:0] BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, DWRD = 3'd3;
  localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

  initial begin
    n_cmp = 0; n_err = 0; dp_act = 1'b0; cyc = 0; resp_first = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    hreset = 1'b1; msel = 1'b0;
    m_haddr = '0; m_htrans = 2'b00; m_hwrite = 1'b0; m_hsize = WORD; m_hburst = 3'd0;
    m_hwdata = '0; m_hwstrb = '0; pend_wdata = '0; pend_wstrb = '0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hreadyout0", {31'd0, bus0.hreadyout}, 32'd1);
    check("rst_hresp0",     {31'd0, bus0.hresp},     32'd0);
    check("rst_hrdata0",    bus0.hrdata,             32'd0);
    check("rst_hexokay0",   {31'd0, bus0.hexokay},   32'd0);
    check("rst_hreadyout3", {31'd0, bus3.hreadyout}, 32'd1);
    check("rst_hrdata3",    bus3.hrdata,             32'd0);
    hreset = 1'b0;

    // Zero wait states: forwarding, sub-word lanes, errors, burst with partial strobes.
    xfer(1, 32'h010, WORD, NS, 32'hDEADBEEF, 4'hF, 0, 0);
    xfer(0, 32'h010, WORD, NS, 0, 0, 0, 32'hDEADBEEF);
    xfer(1, 32'h011, BYTE, NS, 32'h0000AA00, 4'hF, 0, 0);
    xfer(0, 32'h010, WORD, NS, 0, 0, 0, 32'hDEADAAEF);
    xfer(0, 32'h012, HALF, NS, 0, 0, 0, 32'hDEAD0000);
    xfer(0, 32'h1000, WORD, NS, 0, 0, 1, 0);
    xfer(0, 32'h002, WORD, NS, 0, 0, 1, 0);
    xfer(0, 32'h010, DWRD, NS, 0, 0, 1, 0);
    xfer(1, 32'h012, WORD, NS, 32'h11111111, 4'hF, 1, 0);
    xfer(0, 32'h010, WORD, NS, 0, 0, 0, 32'hDEADAAEF);
    xfer(1, 32'h024, WORD, NS, 32'hAAAAAAAA, 4'hF, 0, 0);
    m_hburst = 3'b011;
    xfer(1, 32'h020, WORD, NS, 32'h11111111, 4'hF, 0, 0);
    xfer(1, 32'h024, WORD, SQ, 32'h22222222, 4'h3, 0, 0);
    xfer(1, 32'h028, WORD, SQ, 32'h33333333, 4'hF, 0, 0);
    xfer(1, 32'h02C, WORD, SQ, 32'h44444444, 4'hF, 0, 0);
    m_hburst = 3'd0;
    xfer(1, 32'h020, WORD, NS, 32'hFFFFFFFF, 4'h0, 0, 0);
    xfer(0, 32'h020, WORD, NS, 0, 0, 0, 32'h11111111);
    xfer(0, 32'h024, WORD, NS, 0, 0, 0, 32'hAAAA2222);
    xfer(0, 32'h028, WORD, NS, 0, 0, 0, 32'h33333333);
    xfer(0, 32'h02C, WORD, NS, 0, 0, 0, 32'h44444444);
    m_hburst = 3'b001;
    xfer(1, 32'hFFC, WORD, NS, 32'hCAFEF00D, 4'hF, 0, 0);
    xfer(1, 32'h1000, WORD, SQ, 32'h55555555, 4'hF, 1, 0);
    m_hburst = 3'd0;
    xfer(0, 32'hFFC, WORD, NS, 0, 0, 0, 32'hCAFEF00D);
    idle_bus();

    // Three wait states.
    msel = 1'b1;
    xfer(1, 32'h010, WORD, NS, 32'hDEADBEEF, 4'hF, 0, 0);
    xfer(0, 32'h010, WORD, NS, 0, 0, 0, 32'hDEADBEEF);
    xfer(0, 32'h1000, WORD, NS, 0, 0, 1, 0);
    idle_bus();

    // Reset during the wait states of a write.
    xfer(1, 32'h010, WORD, NS, 32'h12345678, 4'hF, 0, 0);
    m_htrans = 2'b00;
    m_hwdata = pend_wdata;
    m_hwstrb = pend_wstrb;
    @(posedge hclk);
    #3;
    hreset = 1'b1;
    #1;
    check("midrst_hreadyout", {31'd0, bus3.hreadyout}, 32'd1);
    check("midrst_hresp",     {31'd0, bus3.hresp},     32'd0);
    check("midrst_hrdata",    bus3.hrdata,             32'd0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    pend_wdata = '0;
    pend_wstrb = '0;
    xfer(0, 32'h010, WORD, NS, 0, 0, 0, 32'hDEADBEEF);
    idle_bus();

    repeat (3) @(posedge hclk);
    #1;
    check("sb_drained", q.size(), 32'd0);
    check("hexokay0", {31'd0, bus0.hexokay}, 32'd0);
    check("hexokay3", {31'd0, bus3.hexokay}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
